// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared definitions for the pulse train generator.
//   state_t       - FSM states (IDLE, HIGH, LOW)
//   CNT_W_DEFAULT - default width of the pulse-count and phase-width fields
package pulse_train_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// pulse_phase_timer: loadable down-counter used to time one HIGH or LOW phase.
//   clk      - rising-edge clock
//   reset    - synchronous, active-high; clears the count
//   load     - load load_val (takes priority over en)
//   en       - decrement by one; holds at zero, never wraps
//   load_val - value to load
//   zero     - count is zero
module pulse_phase_timer
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable burst generator. On start it emits n_pulses
// pulses of t_high high cycles separated by t_low low cycles (0 counts as 1),
// optionally repeating the burst until stop.
//   clk         - rising-edge clock
//   reset       - synchronous, active-high
//   start       - burst request, honoured only in IDLE
//   stop        - abort to IDLE; overrides everything except reset
//   repeat_mode - latched at start; 1 = restart the burst automatically
//                 (named repeat_mode because repeat is a reserved word)
//   n_pulses    - pulses per burst, latched at start; 0 gives a bare done
//   t_high      - high-phase length in cycles, latched at start
//   t_low       - low-phase length in cycles, latched at start
//   signal      - registered pulse output
//   busy        - registered, high while not IDLE
//   done        - registered one-cycle strobe at the end of each burst
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_mode,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [CNT_W-1:0] t_high,
    input  logic [CNT_W-1:0] t_low,
    output logic             signal,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Phase counter load value: max(t,1) - 1.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : (t - ONE);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             done_d;

    logic [CNT_W-1:0] cfg_n_q, cfg_th_q, cfg_tl_q;
    logic             cfg_rpt_q;
    logic             cfg_latch;

    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    pulse_phase_timer #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        done_d    = 1'b0;
        cfg_latch = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (n_pulses != '0) begin
                            // First phase is loaded straight from the inputs,
                            // which are latched on the same edge.
                            cfg_latch = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_val   = len_m1(t_high);
                            pcnt_d    = n_pulses - ONE;
                            state_d   = HIGH;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (tmr_zero) begin
                        if (pcnt_q != '0) begin
                            tmr_load = 1'b1;
                            tmr_val  = len_m1(cfg_tl_q);
                            pcnt_d   = pcnt_q - ONE;
                            state_d  = LOW;
                        end else begin
                            done_d = 1'b1;
                            if (cfg_rpt_q) begin
                                tmr_load = 1'b1;
                                tmr_val  = len_m1(cfg_tl_q);
                                pcnt_d   = cfg_n_q - ONE;
                                state_d  = LOW;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                LOW: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = len_m1(cfg_th_q);
                        state_d  = HIGH;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so that signal, busy and
    // done change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            cfg_n_q   <= '0;
            cfg_th_q  <= '0;
            cfg_tl_q  <= '0;
            cfg_rpt_q <= 1'b0;
            signal    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            if (cfg_latch) begin
                cfg_n_q   <= n_pulses;
                cfg_th_q  <= t_high;
                cfg_tl_q  <= t_low;
                cfg_rpt_q <= repeat_mode;
            end
            signal <= (state_d == HIGH);
            busy   <= (state_d != IDLE);
            done   <= done_d;
        end
    end

endmodule
